// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encoding, requester indices
// and the supported RAM read-latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StAck    = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // Wait counter only has to reach RD_LAT_MAX-1.
    localparam int unsigned CNT_W = $clog2(RD_LAT_MAX);

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter. The arbiter uses
// the slave modport; the surrounding system (CPU, loader, RAM) uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and loader requesters,
// either fixed priority (CPU first) or round-robin via the favoured-port pointer.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    input  logic rr_en,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = rr_en ? ptr : PORT_CPU;
        end else if (req1) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and loader accesses onto the single RAM port with registered
// strobes and a done pulse. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

`ifdef MEM_ARB_RR_EN
    localparam logic RrEn = 1'b1;
`else
    localparam logic RrEn = 1'b0;
`endif

    // RD_LAT is only meaningful within RD_LAT_MIN..RD_LAT_MAX.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(RD_LAT - 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             we_q;
    logic             ptr_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic             busy_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic [DW-1:0]    rdata_q;

    logic             pick_winner;
    logic             pick_valid;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    mem_arb_pick u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .ptr    (ptr_q),
        .rr_en  (RrEn),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (pick_winner == PORT_LDR) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_q     <= PORT_CPU;
            we_q        <= 1'b0;
            ptr_q       <= PORT_CPU;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Strobe is raised here so it is visible in the ACCESS cycle.
                    if (pick_valid) begin
                        owner_q     <= pick_winner;
                        we_q        <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        gnt0_q      <= (pick_winner == PORT_CPU);
                        gnt1_q      <= (pick_winner == PORT_LDR);
                        busy_q      <= 1'b1;
                        mem_read_q  <= ~sel_we;
                        mem_write_q <= sel_we;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (cnt_q == CntLast) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        done0_q <= (owner_q == PORT_CPU);
                        done1_q <= (owner_q == PORT_LDR);
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAck: begin
                    done0_q     <= 1'b0;
                    done1_q     <= 1'b0;
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    ptr_q       <= other_port(owner_q);
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-requester
// traffic against a transaction-level model; a second RD_LAT=3 instance.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned LAT  = 1;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT3)) u_dut_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'hA5 : 8'(i * 7 + 1);
    endfunction

    // RAM behind the main instance: RD_LAT-deep read pipeline.
    logic [DW-1:0] ram   [256];
    logic [DW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (bus.mem_write) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rpipe[0] <= bus.mem_read ? ram[bus.mem_addr[7:0]] : 8'hEE;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[LAT-1];

    logic [DW-1:0] rpipe3 [LAT3];
    always @(posedge clk) begin
        rpipe3[0] <= bus3.mem_read ? (bus3.mem_addr[7:0] ^ 8'h5A) : 8'hEE;
        for (int i = 1; i < LAT3; i++) rpipe3[i] <= rpipe3[i-1];
    end
    assign bus3.mem_rdata = rpipe3[LAT3-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    bit          m_act;
    int          m_own;
    int          m_r;
    bit          m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    int          m_last;
    logic [7:0]  ref_mem [256];

    task automatic model_reset();
        m_act   = 1'b0;
        m_own   = 0;
        m_r     = 0;
        m_rdata = 8'h00;
        m_last  = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic model_edge();
        if (!rst) return;
        if (m_act) begin
            m_r++;
            if (m_r == 1 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
            if (m_r == LAT + 1 && !m_we) m_rdata = ref_mem[m_addr[7:0]];
            if (m_r == LAT + 2) m_act = 1'b0;
        end else if (bus.req0 || bus.req1) begin
            m_own   = pick(bus.req0, bus.req1);
            m_act   = 1'b1;
            m_r     = 0;
            m_last  = m_own;
            m_we    = (m_own == 0) ? bus.we0 : bus.we1;
            m_addr  = (m_own == 0) ? bus.addr0 : bus.addr1;
            m_wdata = (m_own == 0) ? bus.wdata0 : bus.wdata1;
        end
    endtask

    function automatic bit m_done(input int p);
        return m_act && m_own == p && m_r == LAT + 1;
    endfunction

    task automatic check_all();
        check_eq("gnt0", bus.gnt0, m_act && m_own == 0);
        check_eq("gnt1", bus.gnt1, m_act && m_own == 1);
        check_eq("done0", bus.done0, m_done(0));
        check_eq("done1", bus.done1, m_done(1));
        check_eq("busy", bus.busy, m_act);
        check_eq("mem_read", bus.mem_read, m_act && m_r == 0 && !m_we);
        check_eq("mem_write", bus.mem_write, m_act && m_r == 0 && m_we);
        check_eq("mem_addr", bus.mem_addr, m_act ? m_addr : 16'h0);
        check_eq("mem_wdata", bus.mem_wdata, m_act ? m_wdata : 8'h0);
        check_eq("rdata", bus.rdata, m_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [15:0] a,
                            input logic [7:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic set_req(input int p, input bit r);
        if (p == 0) bus.req0 = r;
        else        bus.req1 = r;
    endtask

    task automatic run_until_done(input int p, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cycle();
            if (m_done(p)) begin
                hit = 1'b1;
                check_eq({tag, "_done"}, (p == 0) ? bus.done0 : bus.done1, 1);
                set_req(p, 1'b0);
            end
        end
        check_eq({tag, "_timeout"}, hit, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic rand_drive();
        for (int p = 0; p < 2; p++) begin
            bit cur   = (p == 0) ? bus.req0 : bus.req1;
            bit owner = m_act && m_own == p;
            if (owner && m_r == LAT + 1) begin
                if ($urandom_range(1, 0) == 0) set_req(p, 1'b0);
                else set_port(p, 1'b1, 1'($urandom_range(1, 0)), 16'($urandom_range(15, 0)),
                              8'($urandom));
            end else if (owner) begin
                if (cur && $urandom_range(19, 0) == 0) set_req(p, 1'b0);
            end else if (!cur && $urandom_range(2, 0) == 0) begin
                set_port(p, 1'b1, 1'($urandom_range(1, 0)), 16'($urandom_range(15, 0)),
                         8'($urandom));
            end
        end
    endtask

    initial begin
        int  k_done;
        int  n_done;
        int  n_gr;
        int  ord0;
        int  ord1;
        bit  prev0;
        bit  prev1;
        bit  saw;
        set_port(0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0);
        bus3.req0 = 1'b0; bus3.we0 = 1'b0; bus3.addr0 = '0; bus3.wdata0 = '0;
        bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.addr1 = '0; bus3.wdata1 = '0;
        @(negedge clk);
        apply_reset();

        // CPU read of a preloaded location.
        set_port(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        k_done = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 1) begin
                check_eq("t1_gnt0_c1", bus.gnt0, 1);
                check_eq("t1_read_c1", bus.mem_read, 1);
            end
            if (bus.done0 && k_done == 0) begin
                k_done = k;
                check_eq("t1_rdata", bus.rdata, 8'hA5);
            end
            if (m_done(0)) set_req(0, 1'b0);
        end
        check_eq("t1_done_cycle", k_done, 3);

        // Loader write followed by CPU read-back.
        set_port(1, 1'b1, 1'b1, 16'h0003, 8'h3C);
        cycle();
        check_eq("t2_write", bus.mem_write, 1);
        check_eq("t2_addr", bus.mem_addr, 16'h0003);
        check_eq("t2_wdata", bus.mem_wdata, 8'h3C);
        run_until_done(1, "t2_wr");
        set_port(0, 1'b1, 1'b0, 16'h0003, 8'h00);
        run_until_done(0, "t2_rd");
        check_eq("t2_readback", bus.rdata, 8'h3C);
        cycle();

        // Simultaneous requests from reset.
        apply_reset();
        set_port(0, 1'b1, 1'b0, 16'h0011, 8'h00);
        set_port(1, 1'b1, 1'b0, 16'h0012, 8'h00);
        n_done = 0; n_gr = 0; ord0 = 3; ord1 = 3; prev0 = 1'b0; prev1 = 1'b0;
        for (int k = 0; k < 40 && n_done < 2; k++) begin
            cycle();
            if (bus.gnt0 && !prev0) begin
                if (n_gr == 0) ord0 = 0; else if (n_gr == 1) ord1 = 0;
                n_gr++;
            end
            if (bus.gnt1 && !prev1) begin
                if (n_gr == 0) ord0 = 1; else if (n_gr == 1) ord1 = 1;
                n_gr++;
            end
            prev0 = bus.gnt0;
            prev1 = bus.gnt1;
            if (m_act && m_r == LAT + 1) begin
                n_done++;
                if (n_done == 2) begin
                    set_req(0, 1'b0);
                    set_req(1, 1'b0);
                end
            end
        end
        check_eq("t3_two_done", n_done, 2);
        check_eq("t3_order0", ord0, 0);
`ifdef MEM_ARB_RR_EN
        check_eq("t3_order1", ord1, 1);
`else
        check_eq("t3_order1", ord1, 0);
`endif
        repeat (4) cycle();

        // req0 dropped during WAIT.
        set_port(0, 1'b1, 1'b0, 16'h0007, 8'h00);
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (m_act && m_own == 0 && m_r == 1) set_req(0, 1'b0);
            if (bus.done0) saw = 1'b1;
            if (m_done(0)) begin
                cycle();
                check_eq("t4_idle_busy", bus.busy, 0);
                break;
            end
        end
        check_eq("t4_done_seen", saw, 1);

        // Reset during a loader write strobe.
        set_port(1, 1'b1, 1'b1, 16'h0005, 8'h77);
        cycle();
        check_eq("t5_strobe", bus.mem_write, 1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("t5_write_cut", bus.mem_write, 0);
        check_eq("t5_gnt1_cut", bus.gnt1, 0);
        check_eq("t5_busy_cut", bus.busy, 0);
        check_eq("t5_no_done", bus.done1, 0);
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0);
        cycle();
        rst = 1'b1;
        cycle();
        set_port(1, 1'b1, 1'b0, 16'h0005, 8'h00);
        cycle();
        check_eq("t5_restart_gnt1", bus.gnt1, 1);
        run_until_done(1, "t5_rd");
        check_eq("t5_unwritten", bus.rdata, init_val(5));
        cycle();

        // Random traffic from both requesters.
        for (int n = 0; n < 1500; n++) begin
            cycle();
            rand_drive();
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (8) cycle();

        // RD_LAT=3 instance: CPU read.
        bus3.req0  = 1'b1;
        bus3.addr0 = 16'h0020;
        @(posedge clk);
        k_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("lat3_gnt0", bus3.gnt0, 1);
            if (bus3.done0 && k_done == 0) begin
                k_done = k;
                check_eq("lat3_rdata", bus3.rdata, 8'h20 ^ 8'h5A);
                bus3.req0 = 1'b0;
            end else if (k_done == 0) begin
                check_eq("lat3_rdata_hold", bus3.rdata, 8'h00);
            end
        end
        check_eq("lat3_done_cycle", k_done, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single RAM port between the CPU core (requester 0) and the program loader (requester 1: front-panel switch loader or a future serial loader). It sits between both requesters and `ram`, serialises their accesses, drives the RAM strobes, and returns read data with a one-cycle completion pulse. It replaces direct CPU-to-RAM wiring in `top` so that loading and execution can share memory without the `cpustate` gating hack.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 8, data width
- `RD_LAT`, 1, RAM read latency in cycles from strobe to valid `mem_rdata` (legal 1..4)

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1 each  access request from the CPU / loader.
- `we0`, `we1`  in  1 each  1 = write, 0 = read. Sampled at grant.
- `addr0`, `addr1`  in  AW each  request address.
- `wdata0`, `wdata1`  in  DW each  write data.
- `gnt0`, `gnt1`  out  1 each  high for the whole transaction owned by that port.
- `done0`, `done1`  out  1 each  one-cycle completion pulse.
- `rdata`  out  DW  read data. Valid in the `done` cycle and held until the next read completes.
- `busy`  out  1  high in any state other than IDLE.
- `mem_read`, `mem_write`  out  1 each  RAM strobes, one cycle wide.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data.

## Operation
- States: IDLE, ACCESS, WAIT, ACK.
- **IDLE**
  - If any `req` is high: pick a winner, latch its `we`, `addr` and `wdata`, set its `gnt`, then go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (1 cycle)
  - Assert `mem_read` or `mem_write` according to the latched `we`.
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - Go to WAIT with the counter at 0.
- **WAIT**
  - Counter increments each cycle.
  - When the counter reaches `RD_LAT`-1, capture `mem_rdata` into `rdata` (reads only), then go to ACK.
  - Writes also pass through WAIT, so read and write latency are identical.
- **ACK** (1 cycle)
  - Pulse the winner's `done`.
  - `gnt` drops at the end of this cycle.
  - Return to IDLE.
- Default arbitration is fixed priority: port 0 (CPU) wins a simultaneous request.
- `mem_addr` and `mem_wdata` hold their latched values from ACCESS through ACK. They are 0 in IDLE.
- Requester protocol:
  - Hold `req` and its operands stable until `done`.
  - Deassert `req` in the `done` cycle, or keep it high to request back-to-back.
- If `req` drops mid-transaction, the transaction still completes and `done` still pulses. There is no abort.
- A request still high in IDLE after the ACK cycle is re-arbitrated normally. There is no lost or duplicated access.
- Reset values:
  - State IDLE.
  - `gnt*`, `done*`, `busy`, `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_wdata`, `rdata` = 0.
  - Round-robin pointer = port 0 favoured.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). An in-flight write strobe is cut and no `done` is issued.

## Timing
- Request seen high in IDLE at edge N:
  - `gnt` high from N+1.
  - Strobe high in cycle N+1 only.
  - `done` high in cycle N+1+`RD_LAT`+1.
- Total request-to-done latency: `RD_LAT`+2 cycles.
- With `RD_LAT`=1: 3 cycles per access, and back-to-back accesses issue one every 4 cycles (one IDLE cycle between them).
- Outputs are registered. There is no combinational path from `req*` to any output.

## Configuration
- `MEM_ARB_RR_EN`
  - Defined: round-robin arbitration. A 1-bit pointer flips to the other port after each ACK. On simultaneous requests, the port that did not win last wins.
  - Undefined: fixed priority, port 0 always wins. Under continuous CPU requests, port 1 is served only in gaps.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, ACK=2'd3);
  - the port index constants `PORT_CPU`=0 and `PORT_LDR`=1;
  - the legal `RD_LAT` bound.
- Sub-module `mem_arb_pick`: combinational winner selection from (`req0`, `req1`, pointer, RR enable), returning the winner index and a valid flag. The FSM, counter and data latches stay in the parent.

## Test plan
- Single CPU read, `addr0`=16'h0010, RAM holds 8'hA5, `RD_LAT`=1 → `gnt0` in cycle 1, `mem_read` in cycle 1 only, `done0` plus `rdata`=8'hA5 in cycle 3; `gnt1` and `done1` stay 0.
- Loader write, `addr1`=16'h0003, `wdata1`=8'h3C → `mem_write` one cycle with `mem_addr`=16'h0003 and `mem_wdata`=8'h3C; a following CPU read of 16'h0003 returns 8'h3C.
- `req0` and `req1` rise together, both held for two transactions → fixed-priority build: grant order 0,0. `MEM_ARB_RR_EN` build: grant order 0,1.
- `RD_LAT`=3, CPU read → `done0` 5 cycles after the request edge; `rdata` unchanged before `done0`.
- `rst` pulled low in the cycle `mem_write` is high → `mem_write`, `gnt1` and `busy` go to 0 without waiting for a clock edge; no `done1`; after release, a new `req1` starts cleanly from IDLE.
- `req0` dropped in the WAIT cycle → `done0` still pulses; the next IDLE cycle shows `busy`=0.
